// File: rtl/row_fill_pkg.sv
// Shared constants and FSM state type for the row fill engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package row_fill_pkg;
    localparam int PIX_BITS      = 4;
    localparam int PIX_PER_WORD  = 4;
    localparam int WORD_BITS     = PIX_BITS * PIX_PER_WORD;
    localparam int SHEET_X_BITS  = 9;
    localparam int SHEET_Y_BITS  = 9;
    localparam int ROW_ADDR_BITS = 8;
    localparam int LEN_BITS      = 8;
    localparam int PIX_CNT_BITS  = LEN_BITS + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/pixel_packer.sv
// MSB-first pixel packer: first pixel of a group lands in the top bits of word.
// Latency: word/word_valid are combinational with the 4th shifted pixel.
// Backpressure: none; every shift_en consumes pix.
module pixel_packer #(
    parameter int PIX_BITS     = 4,
    parameter int PIX_PER_WORD = 4
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             clr,
    input  logic                             shift_en,
    input  logic [PIX_BITS-1:0]              pix,
    output logic [PIX_BITS*PIX_PER_WORD-1:0] word,
    output logic                             word_valid
);
    localparam int HOLD_BITS = PIX_BITS * (PIX_PER_WORD - 1);
    localparam int CNT_BITS  = $clog2(PIX_PER_WORD);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(PIX_PER_WORD - 1);

    logic [HOLD_BITS-1:0] hold;
    logic [CNT_BITS-1:0]  cnt;

    // The incoming pixel is the last slot, so a full word is ready on the 4th shift.
    assign word       = {hold, pix};
    assign word_valid = shift_en && (cnt == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold <= '0;
            cnt  <= '0;
        end else if (clr) begin
            hold <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            hold <= word[HOLD_BITS-1:0];
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/row_fill_engine.sv
// Copies a span of 4-bit sprite-sheet pixels into row RAM, packed 4 per word.
// Latency: first write 6 cycles after start, then one word every 4 cycles.
// Backpressure: start ignored while ready=0; ROM and RAM never stall.
module row_fill_engine
    import row_fill_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [8:0]  src_x,
    input  logic [8:0]  src_y,
    input  logic [7:0]  dst_word,
    input  logic [7:0]  len_words,
    output logic        ready,
    output logic        done,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_data
);
    state_t state, state_d;
    logic   accept;

    logic [LEN_BITS-1:0]      len_q;
    logic [PIX_CNT_BITS-1:0]  iss_cnt;
    logic                     addr_vld;
    logic                     cap_vld;
    logic [LEN_BITS-1:0]      wr_cnt;
    logic [ROW_ADDR_BITS-1:0] next_wr;
    logic                     last_pix;
    logic                     last_wr;
    logic [WORD_BITS-1:0]     pk_word;
    logic                     pk_vld;

    assign last_pix = (iss_cnt == {len_q, 2'b00} - PIX_CNT_BITS'(1));
    assign last_wr  = ram_we && (wr_cnt == len_q - LEN_BITS'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_words == '0) ? DONE : RUN;
                end
            end
            RUN:     if (last_wr) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    pixel_packer #(
        .PIX_BITS     (PIX_BITS),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_packer (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .clr        (accept),
        .shift_en   (cap_vld),
        .pix        (rom_data),
        .word       (pk_word),
        .word_valid (pk_vld)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ready    <= 1'b1;
            done     <= 1'b0;
            rom_addr <= '0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_data <= '0;
            len_q    <= '0;
            iss_cnt  <= '0;
            addr_vld <= 1'b0;
            cap_vld  <= 1'b0;
            wr_cnt   <= '0;
            next_wr  <= '0;
        end else begin
            ready   <= (state_d != RUN);
            done    <= (state_d == DONE);
            ram_we  <= pk_vld;
            cap_vld <= addr_vld;
            if (ram_we) wr_cnt <= wr_cnt + LEN_BITS'(1);
            if (pk_vld) begin
                ram_addr <= next_wr;
                ram_data <= pk_word;
                next_wr  <= next_wr + ROW_ADDR_BITS'(1);
            end
            if (accept) begin
                len_q    <= len_words;
                iss_cnt  <= '0;
                addr_vld <= (len_words != '0);
                wr_cnt   <= '0;
                next_wr  <= dst_word;
                if (len_words != '0) rom_addr <= {src_y, src_x};
            end else if (addr_vld) begin
                // x wraps within the sheet row; y is fixed for the whole span.
                if (last_pix) begin
                    addr_vld <= 1'b0;
                end else begin
                    iss_cnt  <= iss_cnt + PIX_CNT_BITS'(1);
                    rom_addr <= {rom_addr[SHEET_X_BITS+SHEET_Y_BITS-1:SHEET_X_BITS],
                                 rom_addr[SHEET_X_BITS-1:0] + SHEET_X_BITS'(1)};
                end
            end
        end
    end
endmodule
